// File: rtl/regbus_pkg.sv
// Shared definitions for the register-bus initiator: command op encodings,
// controller states and the read-modify-write merge.
package regbus_pkg;

   typedef enum logic [1:0] {
      OP_WR   = 2'b00,
      OP_RD   = 2'b01,
      OP_RMW  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      RD_WAIT,
      RMW_WR,
      RESP
   } state_e;

   localparam int unsigned MERGE_W = 64;

   // Bits set in mask come from new_val, the rest keep old_val.
   function automatic logic [MERGE_W-1:0] rmw_merge(
      input logic [MERGE_W-1:0] old_val,
      input logic [MERGE_W-1:0] new_val,
      input logic [MERGE_W-1:0] mask
   );
      return (old_val & ~mask) | (new_val & mask);
   endfunction

endpackage

// File: rtl/regbus_master.sv
// Register-bus initiator: one command at a time (write, read, masked RMW),
// exactly one response per command, all outputs registered.
module regbus_master
   import regbus_pkg::*;
#(
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned NUM_REGS = 2,
   parameter int unsigned READ_LAT = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [1:0]        CMD_OP,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [DATA_W-1:0] CMD_WDATA,
   input  logic [DATA_W-1:0] CMD_MASK,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DATA_W-1:0] RSP_DATA,
   output logic              RSP_ERR,
   output logic              WRITE,
   output logic              READ,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] WRITE_DATA,
   input  logic [DATA_W-1:0] READ_DATA
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] mask_q, mask_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              write_q, write_d;
   logic              read_q, read_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic              addr_bad;
   logic              sample;
   logic [DATA_W-1:0] merged;

   assign addr_bad = (32'(CMD_ADDR) >= NUM_REGS);
   assign merged   = DATA_W'(rmw_merge(MERGE_W'(READ_DATA), MERGE_W'(wdata_q), MERGE_W'(mask_q)));

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      write_d     = 1'b0;
      read_d      = 1'b0;
      wr_data_d   = wr_data_q;
      sample      = 1'b0;

      case (state_q)
         IDLE: begin
            if (CMD_VALID) begin
               op_d        = op_e'(CMD_OP);
               addr_d      = CMD_ADDR;
               wdata_d     = CMD_WDATA;
               mask_d      = CMD_MASK;
               cmd_ready_d = 1'b0;
               if (op_e'(CMD_OP) == OP_RSVD || addr_bad) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = '0;
               end else if (op_e'(CMD_OP) == OP_WR) begin
                  state_d   = WR;
                  write_d   = 1'b1;
                  wr_data_d = CMD_WDATA;
               end else begin
                  state_d = RD;
                  read_d  = 1'b1;
               end
            end
         end
         WR: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = wdata_q;
         end
         RD: begin
            if (READ_LAT == 0) begin
               sample = 1'b1;
            end else begin
               cnt_d   = 3'(READ_LAT - 1);
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) sample = 1'b1;
            else             cnt_d  = cnt_q - 3'd1;
         end
         RMW_WR: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = wr_data_q;
         end
         RESP: begin
            if (RSP_READY) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // READ_DATA is captured on the last read-latency cycle; RMW turns it
      // straight into the write-back beat.
      if (sample) begin
         if (op_q == OP_RMW) begin
            state_d   = RMW_WR;
            write_d   = 1'b1;
            wr_data_d = merged;
         end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = READ_DATA;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         op_q        <= OP_WR;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         wr_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         write_q     <= write_d;
         read_q      <= read_d;
         wr_data_q   <= wr_data_d;
      end
   end

   assign CMD_READY  = cmd_ready_q;
   assign RSP_VALID  = rsp_valid_q;
   assign RSP_DATA   = rsp_data_q;
   assign RSP_ERR    = rsp_err_q;
   assign WRITE      = write_q;
   assign READ       = read_q;
   assign ADDR       = addr_q;
   assign WRITE_DATA = wr_data_q;

endmodule

// File: doc/regbus_master.md
Name: regbus_master

Overview:
- Initiator for the team's simple register bus: the WRITE/READ strobe, ADDR, WRITE_DATA and READ_DATA interface that register-map slaves decode.
- Accepts one command at a time over a valid/ready command channel and runs plain writes, reads, or masked read-modify-writes (RMW) on the bus.
- Returns exactly one response per command over a valid/ready response channel.
- Sits between a host/config sequencer and one register-map slave.

Parameters:
- ADDR_W, 3, bus address width.
- DATA_W, 4, bus data width.
- NUM_REGS, 2, number of valid addresses (0..NUM_REGS-1); any other address is an error.
- READ_LAT, 0, cycles from the READ strobe cycle to the READ_DATA sample cycle (0 = same cycle); range 0..7.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when high with CMD_VALID.
- CMD_OP  in  2  00 write, 01 read, 10 RMW, 11 reserved (treated as error).
- CMD_ADDR  in  ADDR_W  target address.
- CMD_WDATA  in  DATA_W  write data.
- CMD_MASK  in  DATA_W  RMW bit mask (1 = take bit from CMD_WDATA).
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed when high with RSP_VALID.
- RSP_DATA  out  DATA_W  read data, or final written value.
- RSP_ERR  out  1  bad address or reserved op.
- WRITE  out  1  bus write strobe.
- READ  out  1  bus read strobe.
- ADDR  out  ADDR_W  bus address.
- WRITE_DATA  out  DATA_W  bus write data.
- READ_DATA  in  DATA_W  bus read data from the slave.

Behaviour:
- All outputs are registered. While RST is high at an edge, the next cycle has CMD_READY=1, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, WRITE=0, READ=0, ADDR=0, WRITE_DATA=0.
- RST mid-operation aborts immediately: no further strobes and no response for the aborted command.
- States:
  - IDLE: CMD_READY=1 only here.
  - WR
  - RD
  - RD_WAIT
  - RMW_WR
  - RESP
- Accepting a command at edge T latches op, addr, wdata and mask. ADDR is driven from the latched address starting in cycle T+1 and held until RESP. CMD_READY drops in T+1.
- Write: WRITE=1 for exactly cycle T+1 with WRITE_DATA=CMD_WDATA. RESP is entered at T+2 with RSP_DATA=CMD_WDATA.
- Read:
  - READ=1 for exactly cycle T+1.
  - READ_DATA is sampled at the end of cycle T+1+READ_LAT; RD_WAIT counts down the READ_LAT cycles.
  - RESP is entered at T+2+READ_LAT with RSP_DATA equal to the sampled value.
- RMW:
  - Read phase is identical to a plain read.
  - Then RMW_WR: WRITE=1 for one cycle (T+2+READ_LAT) with WRITE_DATA = (old & ~MASK) | (WDATA & MASK).
  - RESP is entered at T+3+READ_LAT with RSP_DATA equal to that merged value.
- Error (CMD_ADDR >= NUM_REGS, or op=11): no bus strobe. RESP is entered at T+1 with RSP_ERR=1 and RSP_DATA=0.
- WRITE and READ are never high in the same cycle. Each strobe is high for exactly one cycle per bus access.
- RESP:
  - RSP_VALID=1; RSP_DATA and RSP_ERR are held stable until RSP_READY.
  - On handshake, the block returns to IDLE the next cycle, so CMD_READY=1 one cycle after the response is consumed.
  - No command is accepted in the same cycle as a response handshake.
- Back-to-back throughput for writes: one command per 3 cycles when RSP_READY is tied high.
- Bus outputs not being strobed hold their last values; only the strobes qualify them.
- Width rules: the address comparison is unsigned against NUM_REGS. With NUM_REGS=2^ADDR_W every address is valid and no error path exists.

Decomposition:
- Shared package regbus_pkg holds:
  - op encodings: OP_WR=2'b00, OP_RD=2'b01, OP_RMW=2'b10.
  - the state enum: IDLE, WR, RD, RD_WAIT, RMW_WR, RESP.
  - the RMW merge function.
- Single module otherwise. The READ_LAT countdown is inline; no sub-module is warranted.

Test Plan:
- Reset: hold RST for 2 cycles while CMD_VALID=1 -> CMD_READY=1, WRITE=READ=0, RSP_VALID=0, no command accepted.
- Write: addr=1, data=4'hA, accepted at T -> WRITE=1 only in T+1 with ADDR=1, WRITE_DATA=4'hA; RSP_VALID at T+2, RSP_DATA=4'hA, RSP_ERR=0.
- Read with READ_LAT=0, slave reg1:reg0=2'b10:2'b01 -> READ=1 at T+1; RSP_DATA=4'b1001 at T+2. Repeat with READ_LAT=2 -> RSP_VALID at T+4.
- RMW with old=4'b1001, wdata=4'b0110, mask=4'b0011 -> READ at T+1, WRITE at T+2 with WRITE_DATA=4'b1010, RSP_DATA=4'b1010 at T+3.
- Errors: addr=3 with NUM_REGS=2 -> no strobe, RSP_VALID at T+1, RSP_ERR=1, RSP_DATA=0. Op=11 to addr 0 -> same response.
- Backpressure and abort:
  - RSP_READY low for 5 cycles -> RSP fields stable, CMD_READY=0 throughout; CMD_READY=1 one cycle after the handshake.
  - RST asserted in RD_WAIT -> no response, IDLE after reset.
